control_fc_pipe: RTL

- Parametrised valid-tracking controller for the FC layer datapath.
- Delays the FC input valid through a DEPTH-stage shift chain and exposes every stage as a per-stage enable for the MAC/accumulate pipeline.
- Adds the following over the fixed-depth generation:
  - stall and flush;
  - a runtime-selectable output latency;
  - an in-flight counter and busy flag;
  - a frame_done pulse after FRAME_LEN outputs, so the layer sequencer knows when an FC layer has finished.

---
 rtl/fc_ctrl_pkg.sv | 12 +
 rtl/control_fc_pipe_if.sv | 29 ++
 rtl/fc_frame_counter.sv | 33 +++
 rtl/control_fc_pipe.sv | 61 ++++++
 4 files changed

// File: rtl/fc_ctrl_pkg.sv
// Shared constants and latency-clamp helper for the FC layer valid controller.
package fc_ctrl_pkg;
  localparam int FC_DEPTH      = 7;
  localparam int FC1_FRAME_LEN = 4096;
  localparam int FC2_FRAME_LEN = 4096;
  localparam int FC3_FRAME_LEN = 1000;

  // A zero or out-of-range selection falls back to the full chain depth.
  function automatic int clamp_lat(int sel, int depth);
    return (sel == 0 || sel > depth) ? depth : sel;
  endfunction
endpackage

// File: rtl/control_fc_pipe_if.sv
// Control/status bundle between the FC layer sequencer and the valid-tracking pipe.
interface control_fc_pipe_if #(
  parameter int DEPTH     = 7,
  parameter int FRAME_LEN = 4096
);
  localparam int LAT_W = $clog2(DEPTH + 1);
  localparam int CNT_W = $clog2(DEPTH + 2);
  localparam int FRM_W = $clog2(FRAME_LEN + 1);

  logic             valid_in_FC;
  logic             stall;
  logic             flush;
  logic [LAT_W-1:0] lat_sel;
  logic [DEPTH-1:0] valid_in_FC1;
  logic             valid_out;
  logic [CNT_W-1:0] inflight;
  logic             busy;
  logic [FRM_W-1:0] out_count;
  logic             frame_done;

  modport master (
    output valid_in_FC, stall, flush, lat_sel,
    input  valid_in_FC1, valid_out, inflight, busy, out_count, frame_done
  );
  modport slave (
    input  valid_in_FC, stall, flush, lat_sel,
    output valid_in_FC1, valid_out, inflight, busy, out_count, frame_done
  );
endinterface

// File: rtl/fc_frame_counter.sv
// Counts valid_out pulses per FC layer and pulses frame_done when a layer completes.
module fc_frame_counter #(
  parameter int FRAME_LEN = 4096,
  parameter int FRM_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall,
  input  logic             valid_out,
  output logic [FRM_W-1:0] out_count,
  output logic             frame_done
);
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      out_count  <= '0;
      frame_done <= 1'b0;
    end else if (stall) begin
      frame_done <= 1'b0;
    end else if (valid_out) begin
      // Wrap straight to 0 so the next frame can start with no gap.
      if (out_count == FRM_W'(FRAME_LEN - 1)) begin
        out_count  <= '0;
        frame_done <= 1'b1;
      end else begin
        out_count  <= out_count + FRM_W'(1);
        frame_done <= 1'b0;
      end
    end else begin
      frame_done <= 1'b0;
    end
  end
endmodule

// File: rtl/control_fc_pipe.sv
// FC datapath valid tracker: per-stage enable chain, selectable output tap, in-flight count.
module control_fc_pipe
  import fc_ctrl_pkg::*;
#(
  parameter int DEPTH     = FC_DEPTH,
  parameter int FRAME_LEN = FC1_FRAME_LEN
) (
  input logic               clk,
  input logic               rst,
  control_fc_pipe_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 2);
  localparam int FRM_W = $clog2(FRAME_LEN + 1);

  logic [DEPTH-1:0] taps;
  logic             vout;
  logic             tap_sel;
  logic [CNT_W-1:0] infl;
  int               lat;

  assign lat = clamp_lat(int'(bus.lat_sel), DEPTH);

  always_comb begin
    tap_sel = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      if (lat == k + 1) tap_sel = taps[k];
  end

  // Stages past the selected tap keep shifting; they just never reach valid_out.
  always_ff @(posedge clk) begin
    if (!rst || bus.flush) begin
      taps <= '0;
      vout <= 1'b0;
      infl <= '0;
    end else if (!bus.stall) begin
      taps <= DEPTH'({taps, bus.valid_in_FC});
      vout <= tap_sel;
      infl <= infl + CNT_W'(bus.valid_in_FC) - CNT_W'(vout);
    end
  end

  assert property (@(posedge clk) disable iff (!rst)
    (!bus.flush && !bus.stall) |->
      (32'(infl) + 32'(bus.valid_in_FC) >= 32'(vout)) &&
      (32'(infl) + 32'(bus.valid_in_FC) - 32'(vout) <= 32'(lat + 1)));

  fc_frame_counter #(.FRAME_LEN(FRAME_LEN), .FRM_W(FRM_W)) u_frame (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.flush),
    .stall      (bus.stall),
    .valid_out  (vout),
    .out_count  (bus.out_count),
    .frame_done (bus.frame_done)
  );

  assign bus.valid_in_FC1 = taps;
  assign bus.valid_out    = vout;
  assign bus.inflight     = infl;
  assign bus.busy         = (infl != '0);
endmodule
